// File: rtl/la_capture_ctrl.sv
// ---------------------------------------------------------------------------
// la_capture_ctrl
//   Capture sequencer for a small logic analyser. It samples a probe bus
//   into an external ring buffer. It keeps pre_count samples from before the
//   trigger and post_count samples from after it. When the capture is
//   complete, it walks the buffer read address starting at the oldest
//   retained sample.
//
//   Optional feature: define LA_EDGE_TRIG_EN to add the trig_edge input and
//   edge (change-detect) triggering. In the default build the trigger is a
//   level match only.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   arm, abort               start capture / cancel to IDLE (pulses)
//   probe                    sampled logic inputs (PW bits)
//   trig_mask, trig_value    trigger compare mask and value
//   trig_edge                edge-trigger select (LA_EDGE_TRIG_EN only)
//   pre_count, post_count    samples kept before / after the trigger
//   div                      sample divider, one sample every div+1 clocks
//   rd_start, rd_next        readout start / advance pulses
//   mem_we/waddr/wdata       registered buffer write port
//   mem_raddr                buffer read address
//   state                    IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4 READ=5
//   busy, triggered, done    status flags
// ---------------------------------------------------------------------------
module la_capture_ctrl #(
    parameter int ADDR_W = 4,
    parameter int PW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [PW-1:0]     probe,
    input  logic [PW-1:0]     trig_mask,
    input  logic [PW-1:0]     trig_value,
`ifdef LA_EDGE_TRIG_EN
    input  logic              trig_edge,
`endif
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic [3:0]        div,
    input  logic              rd_start,
    input  logic              rd_next,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [PW-1:0]     mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [2:0]        state,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_READ = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [PW-1:0]       wdata_q, wdata_d;
    logic                trig_q, trig_d;
    logic                done_q, done_d;

    logic                capturing;
    logic                strobe;
    logic                hit;
    logic                level_hit;
    logic                do_write;
    logic [ADDR_W-1:0]   fill_inc;
    logic [ADDR_W-1:0]   rem_dec;

    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign strobe    = capturing && (div_cnt_q == div);
    assign level_hit = ((probe ^ trig_value) & trig_mask) == '0;
    assign fill_inc  = fill_q + 1'b1;
    assign rem_dec   = rem_q - 1'b1;

`ifdef LA_EDGE_TRIG_EN
    // Previous strobed sample; prev_vld_q blocks an edge hit on the first
    // strobe after arm, when prev_q still holds a stale value.
    logic [PW-1:0] prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic          edge_hit;

    assign edge_hit = prev_vld_q && (((probe ^ prev_q) & trig_mask) != '0);
    assign hit      = trig_edge ? edge_hit : level_hit;
`else
    assign hit      = level_hit;
`endif

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        trig_addr_d = trig_addr_q;
        raddr_d     = raddr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        trig_d      = trig_q;
        done_d      = done_q;
        do_write    = 1'b0;
`ifdef LA_EDGE_TRIG_EN
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        if (strobe) begin
            prev_d     = probe;
            prev_vld_d = 1'b1;
        end
`endif

        if (capturing) begin
            div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            S_PRE: begin
                if (strobe) begin
                    do_write = 1'b1;
                    fill_d   = fill_inc;
                    if (fill_inc == pre_count) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Every WAIT strobe is written so the ring holds the most
                // recent pre-trigger history; the matching sample is too.
                if (strobe) begin
                    do_write = 1'b1;
                    if (hit) begin
                        trig_addr_d = wptr_q;
                        trig_d      = 1'b1;
                        rem_d       = post_count;
                        if (post_count == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (strobe) begin
                    do_write = 1'b1;
                    rem_d    = rem_dec;
                    if (rem_dec == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE, DONE, READ: arm accepted here only.
                if (arm) begin
                    state_d   = (pre_count == '0) ? S_WAIT : S_PRE;
                    wptr_d    = '0;
                    fill_d    = '0;
                    div_cnt_d = '0;
                    trig_d    = 1'b0;
                    done_d    = 1'b0;
`ifdef LA_EDGE_TRIG_EN
                    prev_vld_d = 1'b0;
`endif
                end else if (state_q != S_IDLE) begin
                    if (rd_start) begin
                        state_d = S_READ;
                        raddr_d = trig_addr_q - pre_count;
                    end else if (rd_next && (state_q == S_READ)) begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
            end
        endcase

        if (do_write) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = probe;
            wptr_d  = wptr_q + 1'b1;
        end

        // abort overrides everything decided above, including a same-cycle arm.
        if (abort) begin
            state_d   = S_IDLE;
            we_d      = 1'b0;
            trig_d    = 1'b0;
            done_d    = 1'b0;
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            rem_q       <= '0;
            trig_addr_q <= '0;
            raddr_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LA_EDGE_TRIG_EN
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            trig_addr_q <= trig_addr_d;
            raddr_q     <= raddr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
`ifdef LA_EDGE_TRIG_EN
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign mem_raddr = raddr_q;
    assign state     = state_q;
    assign busy      = capturing;
    assign triggered = trig_q;
    assign done      = done_q;

endmodule
